// File: rtl/darkriscv_wb_bridge.sv
// darkriscv_wb_bridge
//
// Turns one darkriscv data-port request (DDREQ/DDACK, DRD/DWR, DBE) into a
// single Wishbone B4 pipelined master transaction toward the data memory port.
// Every output is registered. A watchdog aborts a transaction that stays open
// too long, and failed or aborted accesses are reported on the core's BERR.
//
// Handshakes:
//   core side: core_req_i is held high by the core until core_ack_o pulses
//     for one cycle. core_berr_o and core_rdata_o are meaningful in that cycle.
//   bus side: stb is offered until a clock edge sees wb_stall_i=0 (accept).
//     cyc stays high until wb_ack_i or wb_err_i, or until the watchdog expires.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   core_req_i           request strobe (DDREQ)
//   core_rd_i/core_wr_i  read / write request (exactly one must be set)
//   core_addr_i          byte address
//   core_wdata_i         lane-aligned write data
//   core_be_i            byte enables
//   core_rdata_o         read data, held until the next response
//   core_ack_o           one-cycle acknowledge (DDACK)
//   core_berr_o          bus error, valid with core_ack_o
//   wb_*_o               Wishbone master outputs
//   wb_data_i, wb_ack_i, wb_err_i, wb_stall_i   Wishbone slave responses
//   dbg_state            current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)

module darkriscv_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req_i,
    input  logic        core_rd_i,
    input  logic        core_wr_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_be_i,
    output logic [31:0] core_rdata_o,
    output logic        core_ack_o,
    output logic        core_berr_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // The counter holds the number of completed REQ/WAIT cycles, so seeing
    // TIMEOUT_CYCLES-1 means the current cycle is the last one allowed.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;

    logic        cyc_d, stb_d, we_d, ack_d, berr_d;
    logic [3:0]  sel_d;
    logic [31:0] addr_d, wdata_d, rdata_d;

    // The bus is word addressed; the byte offset is carried by the selects.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^core_addr_i[1:0];

    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = wb_cyc_o;
        stb_d   = wb_stb_o;
        we_d    = wb_we_o;
        sel_d   = wb_sel_o;
        addr_d  = wb_addr_o;
        wdata_d = wb_data_o;
        rdata_d = core_rdata_o;
        ack_d   = 1'b0;
        berr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    if (core_rd_i ^ core_wr_i) begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = core_wr_i;
                        sel_d   = core_be_i;
                        addr_d  = {core_addr_i[31:2], 2'b00};
                        wdata_d = core_wr_i ? core_wdata_i : 32'h0;
                    end else begin
                        // Ambiguous request: answer with an error, no bus cycle.
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        berr_d  = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end

            ST_REQ, ST_WAIT: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                // Response beats the watchdog, which beats the stall handshake.
                if (wb_ack_i || wb_err_i) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    berr_d  = wb_err_i;
                    rdata_d = (!wb_err_i && !wb_we_o) ? wb_data_i : 32'h0;
                end else if (cnt_q == WD_LAST) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                end else if (state_q == ST_REQ && !wb_stall_i) begin
                    state_d = ST_WAIT;
                    stb_d   = 1'b0;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= 4'h0;
            wb_addr_o    <= 32'h0;
            wb_data_o    <= 32'h0;
            core_rdata_o <= 32'h0;
            core_ack_o   <= 1'b0;
            core_berr_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_cyc_o     <= cyc_d;
            wb_stb_o     <= stb_d;
            wb_we_o      <= we_d;
            wb_sel_o     <= sel_d;
            wb_addr_o    <= addr_d;
            wb_data_o    <= wdata_d;
            core_rdata_o <= rdata_d;
            core_ack_o   <= ack_d;
            core_berr_o  <= berr_d;
        end
    end

endmodule

// File: tb/tb_darkriscv_wb_bridge.sv
// Directed testbench for darkriscv_wb_bridge with TIMEOUT_CYCLES=8.
// Inputs are driven and outputs sampled 1 ns after the rising edge; a
// negedge monitor counts stb/cyc/ack cycles and scores every core_ack_o
// pulse against the expected {berr, rdata} queue.

module tb_darkriscv_wb_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i, core_rd_i, core_wr_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_rdata_o;
    logic        core_ack_o, core_berr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
    logic        wb_ack_i, wb_err_i, wb_stall_i;
    logic [1:0]  dbg_state;

    darkriscv_wb_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_rd_i(core_rd_i), .core_wr_i(core_wr_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_be_i(core_be_i),
        .core_rdata_o(core_rdata_o), .core_ack_o(core_ack_o), .core_berr_o(core_berr_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];   // {berr, rdata} per expected core_ack_o
    int stb_cnt = 0;
    int cyc_cnt = 0;
    int ack_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_stb_o) stb_cnt++;
            if (wb_cyc_o) cyc_cnt++;
            if (core_ack_o) begin
                logic [32:0] e;
                ack_cnt++;
                check("ack_cyc_low", 32'(wb_cyc_o), 32'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(core_ack_o), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", core_rdata_o, e[31:0]);
                    check("berr", 32'(core_berr_o), 32'(e[32]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        core_rd_i    = rd;
        core_wr_i    = wr;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        core_be_i    = be;
        core_req_i   = 1'b1;
        step();
    endtask

    task automatic bus_resp(input logic ack, input logic err, input logic [31:0] data);
        wb_ack_i  = ack;
        wb_err_i  = err;
        wb_data_i = data;
        step();
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = 32'h0;
    endtask

    // Waits (bounded) for the ack pulse, then releases the request.
    task automatic wait_ack(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (core_ack_o) seen = 1'b1;
            else step();
        end
        if (!seen) check("ack_timeout", 32'(core_ack_o), 32'(1));
        core_req_i = 1'b0;
        core_rd_i  = 1'b0;
        core_wr_i  = 1'b0;
        step();
        if (seen) check("ack_one_cycle", 32'(core_ack_o), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL tb_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int s_stb, s_cyc, s_ack;
        rst_n = 1'b0;
        core_req_i = 1'b0; core_rd_i = 1'b0; core_wr_i = 1'b0;
        core_addr_i = 32'h0; core_wdata_i = 32'h0; core_be_i = 4'h0;
        wb_data_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;

        // Reset state
        #12;
        check("rst_cyc", 32'(wb_cyc_o), 32'(0));
        check("rst_stb", 32'(wb_stb_o), 32'(0));
        check("rst_ack", 32'(core_ack_o), 32'(0));
        check("rst_berr", 32'(core_berr_o), 32'(0));
        check("rst_rdata", core_rdata_o, 32'h0);
        check("rst_addr", wb_addr_o, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(0));
        #10 rst_n = 1'b1;
        step();

        // Read, no stall
        s_stb = stb_cnt;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        issue(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b1100);
        check("rd_cyc", 32'(wb_cyc_o), 32'(1));
        check("rd_stb", 32'(wb_stb_o), 32'(1));
        check("rd_addr", wb_addr_o, 32'h0000_1004);
        check("rd_sel", 32'(wb_sel_o), 32'hC);
        check("rd_we", 32'(wb_we_o), 32'(0));
        check("rd_wdata", wb_data_o, 32'h0);
        step();
        check("rd_stb_drop", 32'(wb_stb_o), 32'(0));
        check("rd_cyc_hold", 32'(wb_cyc_o), 32'(1));
        bus_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("rd_ack_next", 32'(core_ack_o), 32'(1));
        wait_ack(4);
        check("rd_stb_cycles", 32'(stb_cnt - s_stb), 32'(1));

        // Write with 3 stall cycles
        s_stb = stb_cnt;
        exp_q.push_back({1'b0, 32'h0});
        wb_stall_i = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        check("wr_we", 32'(wb_we_o), 32'(1));
        check("wr_data", wb_data_o, 32'h1234_5678);
        check("wr_sel", 32'(wb_sel_o), 32'hF);
        check("wr_addr", wb_addr_o, 32'h20);
        repeat (3) step();
        wb_stall_i = 1'b0;
        check("wr_stb_stalled", 32'(wb_stb_o), 32'(1));
        step();
        check("wr_stb_drop", 32'(wb_stb_o), 32'(0));
        bus_resp(1'b1, 1'b0, 32'hFFFF_FFFF);
        wait_ack(4);
        check("wr_stb_cycles", 32'(stb_cnt - s_stb), 32'(4));

        // Timeout with a late ack afterwards
        s_cyc = cyc_cnt;
        s_ack = ack_cnt;
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        wait_ack(20);
        check("to_cyc_cycles", 32'(cyc_cnt - s_cyc), 32'(TO));
        step();
        bus_resp(1'b1, 1'b0, 32'h0000_0055);
        step();
        step();
        check("to_single_ack", 32'(ack_cnt - s_ack), 32'(1));
        check("to_idle", 32'(dbg_state), 32'(0));

        // Error on a read
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
        step();
        bus_resp(1'b0, 1'b1, 32'h1111_2222);
        wait_ack(4);

        // Ack and err together: err wins
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'hF);
        step();
        bus_resp(1'b1, 1'b1, 32'h3333_4444);
        wait_ack(4);

        // Ack in the same cycle as watchdog expiry: ack wins
        s_cyc = cyc_cnt;
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        issue(1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'hF);
        repeat (TO - 1) step();
        bus_resp(1'b1, 1'b0, 32'h0BAD_F00D);
        wait_ack(2);
        check("exp_ack_cyc_cycles", 32'(cyc_cnt - s_cyc), 32'(TO));

        // Invalid requests: rd=wr=1 then rd=wr=0
        s_cyc = cyc_cnt;
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 4'hF);
        check("inv_cyc", 32'(wb_cyc_o), 32'(0));
        check("inv_ack_now", 32'(core_ack_o), 32'(1));
        wait_ack(1);
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b0, 1'b0, 32'h0000_0084, 32'h0, 4'hF);
        wait_ack(1);
        check("inv_no_cyc", 32'(cyc_cnt - s_cyc), 32'(0));

        // Asynchronous reset mid-WAIT, then a normal read
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        step();
        check("rw_cyc_before", 32'(wb_cyc_o), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rw_cyc", 32'(wb_cyc_o), 32'(0));
        check("rw_stb", 32'(wb_stb_o), 32'(0));
        check("rw_addr", wb_addr_o, 32'h0);
        check("rw_sel", 32'(wb_sel_o), 32'h0);
        check("rw_state", 32'(dbg_state), 32'(0));
        core_req_i = 1'b0; core_rd_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_q.push_back({1'b0, 32'hCAFE_BABE});
        issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        check("post_rst_cyc", 32'(wb_cyc_o), 32'(1));
        step();
        bus_resp(1'b1, 1'b0, 32'hCAFE_BABE);
        wait_ack(4);
        check("end_state", 32'(dbg_state), 32'(0));
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/darkriscv_wb_bridge.md
# darkriscv_wb_bridge

Converts the darkriscv data-port handshake (DDREQ/DDACK, DRD/DWR, DBE) into single Wishbone B4 pipelined master transactions toward the Controller's data memory port (`data_mem_*`).

- Sits between the core and the memory port, in place of the direct wiring plus ack/data pipeline registers in the top level.
- Adds registered outputs, a bus-timeout watchdog and error reporting on the core's BERR.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: number of cycles a transaction may stay open (REQ+WAIT) before it is aborted. Range 2..2^TIMEOUT_W-1.
- `TIMEOUT_W`, default 10: width of the watchdog counter.

Ports (clock and reset first):
- `clk`  in  1  core clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `core_req_i`  in  1  DDREQ. Held high by the core until it sees `core_ack_o`.
- `core_rd_i`  in  1  DRD, read request.
- `core_wr_i`  in  1  DWR, write request.
- `core_addr_i`  in  32  DADDR, byte address.
- `core_wdata_i`  in  32  DATAO, already lane-aligned.
- `core_be_i`  in  4  DBE, byte enables.
- `core_rdata_o`  out  32  DATAI, read data.
- `core_ack_o`  out  1  DDACK, one-cycle pulse.
- `core_berr_o`  out  1  BERR, valid only with `core_ack_o`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone master controls.
- `wb_sel_o`  out  4  byte selects.
- `wb_addr_o`  out  32  word-aligned address.
- `wb_data_o`  out  32  write data.
- `wb_data_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`, `wb_stall_i`  in  1 each  slave responses.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and RESP. All outputs are registered.
- Reset value of every output is 0. `rst_n` low at any time forces IDLE immediately, drops `wb_cyc_o`/`wb_stb_o` and clears the counter. An in-flight transaction is discarded and never acknowledged.
- IDLE:
  - `core_req_i`=1 with exactly one of rd/wr set: latch the request and go to REQ.
    - `wb_addr_o` = {addr[31:2],2'b00}.
    - `wb_sel_o` = `core_be_i`.
    - `wb_we_o` = `core_wr_i`.
    - `wb_data_o` = `core_wdata_i` on a write, 0 on a read.
    - Assert cyc and stb.
  - `core_req_i`=1 with rd=wr (both or neither): go to RESP with berr=1 and rdata=0. No bus cycle is issued.
- REQ: hold stb until `wb_stall_i`=0 at a clock edge, then drop stb and go to WAIT. cyc stays high.
- REQ/WAIT response: `wb_ack_i` or `wb_err_i` seen in either state ends the transaction.
  - Drop cyc and stb and go to RESP.
  - `core_rdata_o` = `wb_data_i` on a read ack, 0 otherwise.
  - `core_berr_o` = `wb_err_i`.
  - If ack and err are both set, err wins.
- Watchdog:
  - The counter clears on IDLE→REQ and increments each cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, drop cyc and stb and go to RESP with berr=1 and rdata=0.
  - An ack or err arriving in that same cycle takes precedence over the timeout.
- RESP: `core_ack_o`=1 for exactly one cycle, then IDLE. `core_rdata_o` holds its value until the next RESP.
- `wb_ack_i`/`wb_err_i` received in IDLE or RESP (late response after an abort) are ignored.
- The latched request is not re-sampled mid-transaction. Core-side changes are ignored until IDLE.

## Timing
- Request seen at edge N: stb high in cycle N+1.
- Zero-stall accept at edge N+1.
- Ack at edge N+1+k (k≥1): `core_ack_o` high in cycle N+2+k.
- Back-to-back: the core keeps `core_req_i` high with a new request after the ack. IDLE re-samples one cycle after RESP.
  - Minimum issue-to-issue period is 4 cycles with k=1.
- Invalid request: `core_ack_o` in cycle N+1.
- Timeout: stb or cyc high for exactly `TIMEOUT_CYCLES` cycles. `core_ack_o`+berr follow in the next cycle.
- Only one transaction is outstanding at any time. cyc never goes high while in RESP or IDLE.

## Test plan
- Read, no stall:
  - Stimulus: addr 0x0000_1006, be 4'b1100, slave ack 1 cycle after accept with data 0xDEAD_BEEF.
  - Required: `wb_addr_o`=0x0000_1004 and `wb_sel_o`=4'b1100, `wb_we_o`=0, one stb cycle. Then `core_ack_o` pulse with rdata 0xDEAD_BEEF and berr=0.
- Write with stall:
  - Stimulus: addr 0x20, wdata 0x1234_5678, be 4'hF, `wb_stall_i` high 3 cycles.
  - Required: stb high 4 cycles, `wb_we_o`=1, `wb_data_o`=0x1234_5678. After ack, one `core_ack_o` pulse with rdata 0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8, slave never acks.
  - Required: cyc high exactly 8 cycles, then `core_ack_o`=1 with berr=1 and rdata=0. A late ack 2 cycles later produces no second `core_ack_o`.
- Error and collision:
  - Stimulus: `wb_err_i` on a read, then (separately) ack and err asserted together.
  - Required: in both cases `core_berr_o`=1 and rdata=0. Also check ack arriving in the same cycle as the timeout expiry: ack wins, berr=0.
- Invalid request:
  - Stimulus: rd=wr=1 with req.
  - Required: `wb_cyc_o` stays 0, `core_ack_o`+berr in the next cycle.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n`=0 asynchronously while cyc is high.
  - Required: cyc, stb and all outputs go to 0 without waiting for a clock edge. After release, a new read completes normally.
